div_sched: RTL and testbench
============================

Name: div_sched

Overview:
- Controls the signed and unsigned AXI-Stream divider IPs used by the EX-stage ALU for div.w, mod.w, div.wu and mod.wu.
- Accepts one divide request at a time from the EX stage and latches its operands.
- Drives the selected IP's input handshake, waits for its output, and selects the quotient or remainder.
- Stalls the pipeline until the result is ready, and discards in-flight results on a pipeline flush.

Parameters:
- WD_LIMIT, 64: number of WAIT-state cycles after which the watchdog error flag is raised.
- CNT_W, 8: width of the per-operation latency counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- req_valid  in  1  EX stage holds a divide-class instruction.
- req_op  in  4  one-hot: [0] div_w, [1] mod_w, [2] div_wu, [3] mod_wu.
- req_src1  in  32  dividend (rj).
- req_src2  in  32  divisor (rk).
- flush  in  1  pipeline flush (exception or ertn); kills the current operation.
- stall  out  1  holds the EX stage.
- res_valid  out  1  one-cycle result strobe.
- res_data  out  32  quotient or remainder.
- div_src1  out  32  latched dividend, shared by both IPs.
- div_src2  out  32  latched divisor, shared by both IPs.
- s_dividend_tvalid  out  1  signed IP dividend valid.
- s_divisor_tvalid  out  1  signed IP divisor valid.
- s_dividend_tready  in  1  signed IP dividend ready.
- s_divisor_tready  in  1  signed IP divisor ready.
- s_dout_tvalid  in  1  signed IP result valid.
- s_dout_tdata  in  64  signed IP result: [63:32] quotient, [31:0] remainder.
- u_dividend_tvalid, u_divisor_tvalid, u_dividend_tready, u_divisor_tready, u_dout_tvalid, u_dout_tdata: unsigned IP, same meaning and widths as the signed set.
- last_latency  out  CNT_W  cycles from SEND entry to result capture for the last completed operation; saturates.
- wd_err  out  1  sticky watchdog error flag.

Behaviour:
- Reset (synchronous, active-high): state=IDLE. All tvalid outputs=0, res_valid=0, res_data=0, div_src1=div_src2=0, last_latency=0, wd_err=0, kill=0, accept flags=0. Reset mid-operation abandons the IP transaction; no result is produced.
- Request acceptance: a request is one with req_valid=1 and req_op nonzero. A request with req_op=0 is ignored: no stall, no state change.
- stall is combinational: 1 when a request is present and state!=DONE, or when state is SEND or WAIT. stall=0 in DONE.
- IDLE: on a request with flush=0, latch the operands, the op and is_unsigned=req_op[2]|req_op[3]. Next cycle go to SEND.
- SEND:
  - Assert only the selected channel's dividend and divisor tvalid, with div_src1/div_src2 stable.
  - Each side drops its own tvalid the cycle after its tready is sampled high. Readies may arrive in different cycles; per-side accepted flags track this.
  - Once both sides are accepted, go to WAIT.
  - tvalid is never withdrawn before acceptance, including on flush.
- WAIT:
  - On the selected dout_tvalid, capture [63:32] for div ops or [31:0] for mod ops into res_data.
  - Update last_latency. Go to DONE, or to IDLE if kill=1.
  - The unselected IP's dout_tvalid is ignored.
- DONE: res_valid=1 for exactly one cycle. The EX stage consumes the result that cycle. Next state is IDLE; a new request is accepted no earlier than the following cycle.
- Flush:
  - In IDLE: no operation starts.
  - In SEND or WAIT: set kill. The handshake and the wait complete normally, the result is discarded, res_valid stays 0, and the state returns to IDLE.
  - In DONE: res_valid is suppressed.
  - kill is cleared on return to IDLE.
- Watchdog: a WAIT-cycle counter. When it reaches WD_LIMIT, set wd_err; wd_err is cleared only by reset. The state machine keeps waiting.
- last_latency saturates at 2^CNT_W-1.
- Divide by zero: the IP output is passed through unchanged; no special handling.

Decomposition:
- Shared package div_pkg holds:
  - state encoding: IDLE, SEND, WAIT, DONE;
  - req_op bit indices: DIV_W=0, MOD_W=1, DIV_WU=2, MOD_WU=3;
  - result field slices: QUO=[63:32], REM=[31:0].
- One sub-module, axis_src_hs: per-channel tvalid/accepted-flag logic, instantiated twice (dividend, divisor) and muxed onto the signed or unsigned IP.

Test Plan:
- div_w, src1=0xFFFFFFF9 (-7), src2=2, IP readies immediate, dout after 10 cycles -> res_data=0xFFFFFFFD, one-cycle res_valid, stall high from request until DONE.
- mod_wu, src1=0xFFFFFFFF, src2=16 -> u_* tvalids only, s_* tvalids stay 0, res_data=0x0000000F; with div_wu -> 0x0FFFFFFF.
- Staggered readies: dividend_tready at cycle 1, divisor_tready at cycle 4 -> dividend tvalid low from cycle 2, divisor tvalid high through cycle 4, WAIT entered only after cycle 4.
- flush in WAIT on div_w -> no res_valid; IP dout consumed, state returns to IDLE; next request 8/3 mod_w -> res_data=2.
- reset asserted in SEND -> all tvalid=0 and state=IDLE the next cycle; a later request completes correctly.
- WD_LIMIT=4, dout withheld 6 cycles -> wd_err=1 after the 4th WAIT cycle and remains 1; the result is still delivered when dout arrives.

Source files
------------

// File: rtl/div_sched_pkg.sv
// Shared definitions for the EX-stage divider scheduler: FSM states,
// one-hot request-op bit positions and divider result field positions.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Bit positions inside the one-hot req_op vector.
  localparam int DIV_W  = 0;
  localparam int MOD_W  = 1;
  localparam int DIV_WU = 2;
  localparam int MOD_WU = 3;

  // Divider IP result layout: quotient in the upper word, remainder in the lower.
  localparam int QUO_HI = 63;
  localparam int QUO_LO = 32;
  localparam int REM_HI = 31;
  localparam int REM_LO = 0;

  // Pick the quotient or the remainder out of a divider result beat.
  function automatic logic [31:0] sel_result(input logic [63:0] dout, input logic want_quo);
    return want_quo ? dout[QUO_HI:QUO_LO] : dout[REM_HI:REM_LO];
  endfunction

endpackage

// File: rtl/div_sched_if.sv
// Connection between the scheduler and the signed/unsigned AXI-Stream
// divider IPs. Both IPs share the latched operand buses.
interface div_sched_if;
  logic [31:0] div_src1;
  logic [31:0] div_src2;

  logic        s_dividend_tvalid;
  logic        s_divisor_tvalid;
  logic        s_dividend_tready;
  logic        s_divisor_tready;
  logic        s_dout_tvalid;
  logic [63:0] s_dout_tdata;

  logic        u_dividend_tvalid;
  logic        u_divisor_tvalid;
  logic        u_dividend_tready;
  logic        u_divisor_tready;
  logic        u_dout_tvalid;
  logic [63:0] u_dout_tdata;

  // Scheduler side.
  modport master (
    output div_src1, div_src2,
    output s_dividend_tvalid, s_divisor_tvalid, u_dividend_tvalid, u_divisor_tvalid,
    input  s_dividend_tready, s_divisor_tready, u_dividend_tready, u_divisor_tready,
    input  s_dout_tvalid, s_dout_tdata, u_dout_tvalid, u_dout_tdata
  );

  // Divider IP side.
  modport slave (
    input  div_src1, div_src2,
    input  s_dividend_tvalid, s_divisor_tvalid, u_dividend_tvalid, u_divisor_tvalid,
    output s_dividend_tready, s_divisor_tready, u_dividend_tready, u_divisor_tready,
    output s_dout_tvalid, s_dout_tdata, u_dout_tvalid, u_dout_tdata
  );
endinterface

// File: rtl/div_sched_axis_src_hs.sv
// One AXI-Stream source channel: raises tvalid on start, holds it until the
// beat is taken, then remembers that the beat was accepted.
module axis_src_hs (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic tready_i,
  output logic tvalid_o,
  output logic done_o
);

  logic valid_q;
  logic acc_q;

  // Track the beat from start through acceptance; tvalid is never withdrawn early.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      valid_q <= 1'b0;
      acc_q   <= 1'b0;
    end else if (start_i) begin
      valid_q <= 1'b1;
      acc_q   <= 1'b0;
    end else if (valid_q && tready_i) begin
      valid_q <= 1'b0;
      acc_q   <= 1'b1;
    end
  end

  assign tvalid_o = valid_q;
  // Already accepted, or being accepted on this edge.
  assign done_o   = acc_q | (valid_q & tready_i);

endmodule

// File: rtl/div_sched.sv
// EX-stage divide scheduler: latches one div/mod request, hands the operands
// to the signed or unsigned divider IP, waits for its result, and returns the
// quotient or remainder while stalling the pipeline. A flush lets the IP
// transaction finish but throws the result away.
module div_sched
  import div_pkg::*;
#(
  parameter int WD_LIMIT = 64,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_src1,
  input  logic [31:0]      req_src2,
  input  logic             flush,
  output logic             stall,
  output logic             res_valid,
  output logic [31:0]      res_data,
  output logic [CNT_W-1:0] last_latency,
  output logic             wd_err,
  div_sched_if.master      ip
);

  localparam int WD_W = $clog2(WD_LIMIT + 1);

  state_e           state_q;
  logic             uns_q;
  logic             want_quo_q;
  logic [31:0]      src1_q;
  logic [31:0]      src2_q;
  logic             kill_q;
  logic             res_valid_q;
  logic [31:0]      res_data_q;
  logic [CNT_W-1:0] lat_q;
  logic [CNT_W-1:0] lat_d;
  logic [CNT_W-1:0] last_lat_q;
  logic [WD_W-1:0]  wd_cnt_q;
  logic             wd_err_q;

  logic        req_present;
  logic        start;
  logic        dvd_vld, dvs_vld;
  logic        dvd_done, dvs_done;
  logic        dvd_rdy, dvs_rdy;
  logic        dout_vld;
  logic [63:0] dout_data;

  assign req_present = req_valid & (|req_op);
  assign start       = (state_q == IDLE) & req_present & ~flush;

  // Route the selected IP's readies and result back into the shared channel logic.
  assign dvd_rdy   = uns_q ? ip.u_dividend_tready : ip.s_dividend_tready;
  assign dvs_rdy   = uns_q ? ip.u_divisor_tready  : ip.s_divisor_tready;
  assign dout_vld  = uns_q ? ip.u_dout_tvalid     : ip.s_dout_tvalid;
  assign dout_data = uns_q ? ip.u_dout_tdata      : ip.s_dout_tdata;

  axis_src_hs u_dvd_hs (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start),
    .tready_i (dvd_rdy),
    .tvalid_o (dvd_vld),
    .done_o   (dvd_done)
  );

  axis_src_hs u_dvs_hs (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start),
    .tready_i (dvs_rdy),
    .tvalid_o (dvs_vld),
    .done_o   (dvs_done)
  );

  assign ip.s_dividend_tvalid = dvd_vld & ~uns_q;
  assign ip.s_divisor_tvalid  = dvs_vld & ~uns_q;
  assign ip.u_dividend_tvalid = dvd_vld &  uns_q;
  assign ip.u_divisor_tvalid  = dvs_vld &  uns_q;
  assign ip.div_src1          = src1_q;
  assign ip.div_src2          = src2_q;

  // Saturating latency increment.
  assign lat_d = (lat_q == {CNT_W{1'b1}}) ? lat_q : lat_q + CNT_W'(1);

  // Operation sequencing, result capture, latency and watchdog bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      uns_q       <= 1'b0;
      want_quo_q  <= 1'b0;
      src1_q      <= '0;
      src2_q      <= '0;
      kill_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      lat_q       <= '0;
      last_lat_q  <= '0;
      wd_cnt_q    <= '0;
      wd_err_q    <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          kill_q <= 1'b0;
          if (start) begin
            uns_q      <= req_op[DIV_WU] | req_op[MOD_WU];
            want_quo_q <= req_op[DIV_W]  | req_op[DIV_WU];
            src1_q     <= req_src1;
            src2_q     <= req_src2;
            lat_q      <= '0;
            wd_cnt_q   <= '0;
            state_q    <= SEND;
          end
        end
        SEND: begin
          lat_q <= lat_d;
          if (flush) kill_q <= 1'b1;
          if (dvd_done && dvs_done) state_q <= WAIT;
        end
        WAIT: begin
          lat_q <= lat_d;
          if (flush) kill_q <= 1'b1;
          if (wd_cnt_q == WD_W'(WD_LIMIT - 1)) wd_err_q <= 1'b1;
          if (wd_cnt_q != WD_W'(WD_LIMIT)) wd_cnt_q <= wd_cnt_q + WD_W'(1);
          if (dout_vld) begin
            res_data_q <= sel_result(dout_data, want_quo_q);
            last_lat_q <= lat_d;
            if (kill_q || flush) begin
              kill_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              res_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          kill_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall        = (req_present && state_q != DONE) || state_q == SEND || state_q == WAIT;
  // A flush landing in DONE must still suppress the strobe.
  assign res_valid    = res_valid_q & ~flush;
  assign res_data     = res_data_q;
  assign last_latency = last_lat_q;
  assign wd_err       = wd_err_q;

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: a directed vector table, hand-written
// flush/reset sequences and randomized operations, all judged against a
// behavioural divider model and cycle-level timing expectations.
module tb_div_sched;
  import div_pkg::*;

  localparam int WD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        flush;
  logic        stall, res_valid;
  logic [31:0] res_data;
  logic [7:0]  last_latency;
  logic        wd_err;

  int total = 0;
  int bad   = 0;
  bit wd_model = 0;

  div_sched_if ip ();

  div_sched #(.WD_LIMIT(WD), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_src1     (req_src1),
    .req_src2     (req_src2),
    .flush        (flush),
    .stall        (stall),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .last_latency (last_latency),
    .wd_err       (wd_err),
    .ip           (ip)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural divider IP: {quotient, remainder}; divide by zero gives all-ones / dividend.
  function automatic logic [63:0] ip_out(input bit uns, input logic [31:0] a, input logic [31:0] b);
    longint q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (uns) begin
      q = longint'({32'd0, a}) / longint'({32'd0, b});
      r = longint'({32'd0, a}) % longint'({32'd0, b});
    end else begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end
    return {q[31:0], r[31:0]};
  endfunction

  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] d;
    d = ip_out(op[2] | op[3], a, b);
    return (op[0] | op[2]) ? d[63:32] : d[31:0];
  endfunction

  task automatic idle_ip();
    ip.s_dividend_tready = 1'b0; ip.s_divisor_tready = 1'b0;
    ip.u_dividend_tready = 1'b0; ip.u_divisor_tready = 1'b0;
    ip.s_dout_tvalid = 1'b0; ip.s_dout_tdata = '0;
    ip.u_dout_tvalid = 1'b0; ip.u_dout_tdata = '0;
  endtask

  // One complete operation. k counts cycles from the first SEND cycle.
  // flush_k < 0 means no flush; flush_k == kd+1 flushes in the result cycle.
  task automatic do_op(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int dvd_dly, input int dvs_dly, input int dout_dly, input int flush_k,
                       input logic [31:0] exp_res);
    bit uns = op[2] | op[3];
    int w   = ((dvd_dly > dvs_dly) ? dvd_dly : dvs_dly) + 1;
    int kd  = w + dout_dly;
    bit killed = 0;
    logic [31:0] sa = '0, sb = '0;
    logic sel_v, junk_v;

    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b; flush = 1'b0;
    idle_ip();
    #1;
    check({nm, "_req_stall"}, stall, 1'b1);
    check({nm, "_req_tvalid"}, {ip.s_dividend_tvalid, ip.s_divisor_tvalid,
                                ip.u_dividend_tvalid, ip.u_divisor_tvalid}, 4'b0);

    for (int k = 0; k <= kd + 1; k++) begin
      @(negedge clk);
      if (k == flush_k) killed = 1;
      flush = (k == flush_k);
      if (killed) req_valid = 1'b0;
      ip.s_dividend_tready = uns ? 1'b1 : (k == dvd_dly);
      ip.s_divisor_tready  = uns ? 1'b1 : (k == dvs_dly);
      ip.u_dividend_tready = uns ? (k == dvd_dly) : 1'b1;
      ip.u_divisor_tready  = uns ? (k == dvs_dly) : 1'b1;
      sel_v  = (k == kd);
      junk_v = (k >= w && k < kd);
      if (uns) begin
        ip.u_dout_tvalid = sel_v;  ip.u_dout_tdata = sel_v ? ip_out(1'b1, sa, sb) : 64'd0;
        ip.s_dout_tvalid = junk_v; ip.s_dout_tdata = {$urandom, $urandom};
      end else begin
        ip.s_dout_tvalid = sel_v;  ip.s_dout_tdata = sel_v ? ip_out(1'b0, sa, sb) : 64'd0;
        ip.u_dout_tvalid = junk_v; ip.u_dout_tdata = {$urandom, $urandom};
      end
      #1;
      if (k == dvd_dly) sa = ip.div_src1;
      if (k == dvs_dly) sb = ip.div_src2;
      check({nm, "_dvd_tvalid"}, uns ? ip.u_dividend_tvalid : ip.s_dividend_tvalid, k <= dvd_dly);
      check({nm, "_dvs_tvalid"}, uns ? ip.u_divisor_tvalid : ip.s_divisor_tvalid, k <= dvs_dly);
      check({nm, "_other_tvalid"}, uns ? {ip.s_dividend_tvalid, ip.s_divisor_tvalid}
                                       : {ip.u_dividend_tvalid, ip.u_divisor_tvalid}, 2'b00);
      if (k < w) check({nm, "_src"}, {ip.div_src1, ip.div_src2}, {a, b});
      check({nm, "_stall"}, stall, k <= kd);
      check({nm, "_res_valid"}, res_valid, (k == kd + 1) && !killed);
      if (k == kd + 1 && !killed) begin
        check({nm, "_res_data"}, res_data, exp_res);
        check({nm, "_latency"}, last_latency, kd + 1);
      end
      if (k - w >= WD) wd_model = 1;
      check({nm, "_wd_err"}, wd_err, wd_model);
    end

    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    idle_ip();
    #1;
    check({nm, "_post_stall"}, stall, 1'b0);
    check({nm, "_post_res_valid"}, res_valid, 1'b0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    int          dvd_dly, dvs_dly, dout_dly, flush_k;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{4'b0001, 32'hFFFF_FFF9, 32'd2,        0, 0, 10, -1, 32'hFFFF_FFFD};
    vecs[1]  = '{4'b1000, 32'hFFFF_FFFF, 32'd16,       0, 0, 2,  -1, 32'h0000_000F};
    vecs[2]  = '{4'b0100, 32'hFFFF_FFFF, 32'd16,       0, 0, 2,  -1, 32'h0FFF_FFFF};
    vecs[3]  = '{4'b0001, 32'd100,       32'd7,        1, 4, 1,  -1, 32'd14};
    vecs[4]  = '{4'b0001, 32'hFFFF_FFF9, 32'd2,        0, 0, 3,  2,  32'd0};
    vecs[5]  = '{4'b0010, 32'd8,         32'd3,        0, 0, 1,  -1, 32'd2};
    vecs[6]  = '{4'b0010, 32'hFFFF_FFF9, 32'd2,        0, 0, 1,  -1, 32'hFFFF_FFFF};
    vecs[7]  = '{4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, -1, 32'h8000_0000};
    vecs[8]  = '{4'b0100, 32'd5,         32'd0,        0, 0, 1,  -1, 32'hFFFF_FFFF};
    vecs[9]  = '{4'b0010, 32'd5,         32'd0,        0, 0, 1,  -1, 32'd5};
    vecs[10] = '{4'b0100, 32'd50,        32'd5,        2, 0, 1,  1,  32'd0};
    vecs[11] = '{4'b1000, 32'd50,        32'd7,        0, 0, 1,  3,  32'd0};
    vecs[12] = '{4'b1000, 32'd50,        32'd7,        3, 0, 0,  -1, 32'd1};

    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0; flush = 1'b0;
    idle_ip();
    repeat (2) @(negedge clk);
    #1;
    check("rst_tvalid", {ip.s_dividend_tvalid, ip.s_divisor_tvalid,
                         ip.u_dividend_tvalid, ip.u_divisor_tvalid}, 4'b0);
    check("rst_outputs", {stall, res_valid, wd_err}, 3'b0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_src", {ip.div_src1, ip.div_src2}, 64'd0);
    check("rst_latency", last_latency, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    // A request with no op bit set is ignored.
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b0000; req_src1 = 32'd9; req_src2 = 32'd3;
    #1;
    check("nop_stall", stall, 1'b0);
    @(negedge clk);
    #1;
    check("nop_tvalid", {ip.s_dividend_tvalid, ip.u_dividend_tvalid}, 2'b00);
    check("nop_stall2", stall, 1'b0);
    req_valid = 1'b0;

    for (int i = 0; i < 13; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dvd_dly,
            vecs[i].dvs_dly, vecs[i].dout_dly, vecs[i].flush_k, vecs[i].exp);

    // Flush in IDLE: the request must not start.
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b0001; req_src1 = 32'd40; req_src2 = 32'd4; flush = 1'b1;
    #1;
    check("idle_flush_stall", stall, 1'b1);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #1;
    check("idle_flush_tvalid", {ip.s_dividend_tvalid, ip.s_divisor_tvalid}, 2'b00);
    check("idle_flush_stall2", stall, 1'b0);

    // Randomized operations against the behavioural model.
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      int d1, d2, dd, fk;
      op = 4'b0001 << $urandom_range(0, 3);
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
      d1 = $urandom_range(0, 3);
      d2 = $urandom_range(0, 3);
      dd = $urandom_range(0, 4);
      fk = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ((d1 > d2) ? d1 : d2) + dd + 2) : -1;
      do_op($sformatf("rnd%0d", i), op, a, b, d1, d2, dd, fk, ref_res(op, a, b));
    end

    // Reset in SEND abandons the transaction.
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b0001; req_src1 = 32'd100; req_src2 = 32'd7;
    idle_ip();
    @(negedge clk);
    #1;
    check("rstsend_tvalid_before", ip.s_dividend_tvalid, 1'b1);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wd_model = 0;
    #1;
    check("rstsend_tvalid", {ip.s_dividend_tvalid, ip.s_divisor_tvalid,
                             ip.u_dividend_tvalid, ip.u_divisor_tvalid}, 4'b0);
    check("rstsend_stall", stall, 1'b0);
    check("rstsend_wd_err", wd_err, 1'b0);
    check("rstsend_latency", last_latency, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rstsend_no_result", {res_valid, stall}, 2'b00);
    end
    do_op("after_reset", 4'b0010, 32'd8, 32'd3, 0, 0, 1, -1, 32'd2);

    // Watchdog: six WAIT cycles without a result, then the result arrives.
    do_op("watchdog", 4'b0001, 32'd1000, 32'd10, 0, 0, 6, -1, 32'd100);
    check("watchdog_sticky", wd_err, 1'b1);
    do_op("after_wd", 4'b1000, 32'd1000, 32'd7, 1, 0, 0, -1, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
